// File: rtl/vram_arbiter.sv
// Video RAM arbiter: single-port RAM shared by the video fetcher (absolute priority) and the CPU.
// Latency: grant is combinational in the issue cycle; vid_valid / cpu_ack pulse exactly one cycle later.
// Backpressure: video never stalls; CPU holds cpu_req until cpu_ack, at most one access per 2 cycles.
module vram_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic              vid_active,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              blank_only,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        stall_count
);

    // Last cycle's grant; doubles as the registered vid_valid / cpu_ack source.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_VID  = 2'd1,
        S_CPU  = 2'd2
    } state_t;

    state_t            state;
    logic              we_q;          // direction of the CPU access being acknowledged
    logic [DATA_W-1:0] cpu_rdata_q;   // last CPU read byte, held across writes and idle cycles
    logic [DATA_W-1:0] vid_data_q;    // last video byte, held between fetches

    logic cpu_elig;
    logic vid_gnt;
    logic cpu_gnt;
    logic stall_inc;

    // The ack cycle (state CPU) never re-issues the still-high cpu_req, which caps CPU
    // throughput at one access per two cycles. blank_only/vid_active act in the same cycle.
    assign cpu_elig  = cpu_req && (state != S_CPU) && (!blank_only || !vid_active);
    // Nothing is issued while reset is high, so an access cannot slip into the RAM during reset.
    assign vid_gnt   = !reset && vid_req;
    assign cpu_gnt   = !reset && cpu_elig && !vid_req;
    // A CPU cycle counts as lost when it is waiting (not in its own ack cycle) and not granted.
    assign stall_inc = cpu_req && (state != S_CPU) && !cpu_gnt;

    // Drive the RAM port from the current-cycle grant.
    always_comb begin
        mem_addr = '0;
        mem_we   = 1'b0;
        if (vid_gnt) begin
            mem_addr = vid_addr;
        end else if (cpu_gnt) begin
            mem_addr = cpu_addr;
            mem_we   = cpu_we;
        end
    end

    assign mem_wdata = cpu_wdata;

    // Record the grant, latch CPU direction, capture returned bytes and count CPU stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            we_q        <= 1'b0;
            cpu_rdata_q <= '0;
            vid_data_q  <= '0;
            stall_count <= 8'd0;
        end else begin
            if (vid_gnt) begin
                state <= S_VID;
            end else if (cpu_gnt) begin
                state <= S_CPU;
            end else begin
                state <= S_IDLE;
            end

            if (cpu_gnt) begin
                we_q <= cpu_we;
            end

            if (state == S_VID) begin
                vid_data_q <= mem_rdata;
            end
            if (state == S_CPU && !we_q) begin
                cpu_rdata_q <= mem_rdata;
            end

            if (stall_inc && stall_count != 8'hFF) begin
                stall_count <= stall_count + 8'd1;
            end
        end
    end

    // Responses: the RAM returns data one cycle after the address, so the byte is passed straight
    // through in the response cycle and held afterwards. Reset masks a response still in flight.
    always_comb begin
        vid_valid = (state == S_VID) && !reset;
        cpu_ack   = (state == S_CPU) && !reset;
        vid_data  = '0;
        cpu_rdata = '0;
        if (!reset) begin
            vid_data  = vid_valid ? mem_rdata : vid_data_q;
            cpu_rdata = (cpu_ack && !we_q) ? mem_rdata : cpu_rdata_q;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter with a registered-read RAM model.
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after edges or input changes.
// Each scenario task performs its own comparisons against hand-computed values.
module tb_vram_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_active;
    logic [DATA_W-1:0] vid_data;
    logic              vid_valid;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              blank_only;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [7:0]        stall_count;

    logic [DATA_W-1:0] ram [0:2047];

    int n_cmp = 0;
    int n_bad = 0;

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_active(vid_active),
        .vid_data(vid_data), .vid_valid(vid_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .blank_only(blank_only),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Single-port RAM, registered read
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        vid_req = 0; vid_addr = '0; vid_active = 0; blank_only = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        #1;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1;
        tick(); tick();
        vid_req = 1; vid_addr = 11'h155; cpu_req = 1; cpu_we = 1; cpu_addr = 11'h0AA;
        #1;
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we: got %0h want 0", mem_we); end
        n_cmp++; if (mem_addr !== 11'h000) begin n_bad++; $display("FAIL rst_mem_addr: got %0h want 0", mem_addr); end
        tick();
        n_cmp++; if (vid_valid !== 1'b0) begin n_bad++; $display("FAIL rst_vid_valid: got %0h want 0", vid_valid); end
        n_cmp++; if (cpu_ack !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_ack: got %0h want 0", cpu_ack); end
        n_cmp++; if (stall_count !== 8'd0) begin n_bad++; $display("FAIL rst_stall: got %0d want 0", stall_count); end
        n_cmp++; if (cpu_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_cpu_rdata: got %0h want 0", cpu_rdata); end
        n_cmp++; if (vid_data !== 8'h00) begin n_bad++; $display("FAIL rst_vid_data: got %0h want 0", vid_data); end
        n_cmp++; if (ram[11'h0AA] !== 8'h0F) begin n_bad++; $display("FAIL rst_ram_unwritten: got %0h want 0f", ram[11'h0AA]); end
        idle_inputs();
        reset = 0;
        tick();
    endtask

    task automatic test_cpu_write;
        cpu_req = 1; cpu_we = 1; cpu_addr = 11'h123; cpu_wdata = 8'h5A;
        #1;
        n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL wr_mem_we: got %0h want 1", mem_we); end
        n_cmp++; if (mem_addr !== 11'h123) begin n_bad++; $display("FAIL wr_mem_addr: got %0h want 123", mem_addr); end
        n_cmp++; if (mem_wdata !== 8'h5A) begin n_bad++; $display("FAIL wr_mem_wdata: got %0h want 5a", mem_wdata); end
        tick();
        n_cmp++; if (cpu_ack !== 1'b1) begin n_bad++; $display("FAIL wr_ack: got %0h want 1", cpu_ack); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL wr_no_reissue: got %0h want 0", mem_we); end
        n_cmp++; if (stall_count !== 8'd0) begin n_bad++; $display("FAIL wr_stall: got %0d want 0", stall_count); end
        n_cmp++; if (cpu_rdata !== 8'h00) begin n_bad++; $display("FAIL wr_rdata_hold: got %0h want 0", cpu_rdata); end
        cpu_req = 0;
        tick();
        n_cmp++; if (cpu_ack !== 1'b0) begin n_bad++; $display("FAIL wr_ack_pulse: got %0h want 0", cpu_ack); end
        n_cmp++; if (ram[11'h123] !== 8'h5A) begin n_bad++; $display("FAIL wr_ram: got %0h want 5a", ram[11'h123]); end
    endtask

    task automatic test_collision;
        vid_req = 1; vid_addr = 11'h040;
        cpu_req = 1; cpu_we = 0; cpu_addr = 11'h7F0;
        #1;
        n_cmp++; if (mem_addr !== 11'h040) begin n_bad++; $display("FAIL col_vid_addr: got %0h want 040", mem_addr); end
        tick();
        vid_req = 0;
        n_cmp++; if (vid_valid !== 1'b1) begin n_bad++; $display("FAIL col_vid_valid: got %0h want 1", vid_valid); end
        n_cmp++; if (vid_data !== 8'h11) begin n_bad++; $display("FAIL col_vid_data: got %0h want 11", vid_data); end
        n_cmp++; if (cpu_ack !== 1'b0) begin n_bad++; $display("FAIL col_no_ack: got %0h want 0", cpu_ack); end
        n_cmp++; if (stall_count !== 8'd1) begin n_bad++; $display("FAIL col_stall: got %0d want 1", stall_count); end
        #1;
        n_cmp++; if (mem_addr !== 11'h7F0) begin n_bad++; $display("FAIL col_cpu_issue: got %0h want 7f0", mem_addr); end
        tick();
        n_cmp++; if (cpu_ack !== 1'b1) begin n_bad++; $display("FAIL col_ack: got %0h want 1", cpu_ack); end
        n_cmp++; if (cpu_rdata !== 8'hC3) begin n_bad++; $display("FAIL col_rdata: got %0h want c3", cpu_rdata); end
        n_cmp++; if (vid_valid !== 1'b0) begin n_bad++; $display("FAIL col_vid_pulse: got %0h want 0", vid_valid); end
        cpu_req = 0;
        tick();
        n_cmp++; if (cpu_rdata !== 8'hC3) begin n_bad++; $display("FAIL col_rdata_hold: got %0h want c3", cpu_rdata); end
        n_cmp++; if (stall_count !== 8'd1) begin n_bad++; $display("FAIL col_stall_final: got %0d want 1", stall_count); end
    endtask

    task automatic test_blank_only;
        do_reset();
        blank_only = 1; vid_active = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 11'h010;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++; if (cpu_ack !== 1'b0) begin n_bad++; $display("FAIL blank_no_ack[%0d]: got %0h want 0", i, cpu_ack); end
        end
        n_cmp++; if (stall_count !== 8'd10) begin n_bad++; $display("FAIL blank_stall: got %0d want 10", stall_count); end
        vid_active = 0;
        #1;
        n_cmp++; if (mem_addr !== 11'h010) begin n_bad++; $display("FAIL blank_issue: got %0h want 010", mem_addr); end
        tick();
        n_cmp++; if (cpu_ack !== 1'b1) begin n_bad++; $display("FAIL blank_ack: got %0h want 1", cpu_ack); end
        n_cmp++; if (cpu_rdata !== 8'h3C) begin n_bad++; $display("FAIL blank_rdata: got %0h want 3c", cpu_rdata); end
        n_cmp++; if (stall_count !== 8'd10) begin n_bad++; $display("FAIL blank_stall_after: got %0d want 10", stall_count); end
        cpu_req = 0; blank_only = 0;
        tick();
    endtask

    task automatic test_saturate;
        do_reset();
        blank_only = 1; vid_active = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 11'h001;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 254) begin
                n_cmp++; if (stall_count !== 8'd254) begin n_bad++; $display("FAIL sat_254: got %0d want 254", stall_count); end
            end
        end
        n_cmp++; if (stall_count !== 8'd255) begin n_bad++; $display("FAIL sat_255: got %0d want 255", stall_count); end
        n_cmp++; if (cpu_ack !== 1'b0) begin n_bad++; $display("FAIL sat_no_ack: got %0h want 0", cpu_ack); end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        // issue a write, then assert reset in its ack cycle
        cpu_req = 1; cpu_we = 1; cpu_addr = 11'h200; cpu_wdata = 8'hEE;
        tick();
        reset = 1;
        #1;
        n_cmp++; if (cpu_ack !== 1'b0) begin n_bad++; $display("FAIL rmid_ack: got %0h want 0", cpu_ack); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rmid_mem_we: got %0h want 0", mem_we); end
        // a write presented while reset is high must not reach the RAM
        cpu_addr = 11'h201; cpu_wdata = 8'h77;
        tick();
        n_cmp++; if (cpu_ack !== 1'b0) begin n_bad++; $display("FAIL rmid_ack_after: got %0h want 0", cpu_ack); end
        n_cmp++; if (stall_count !== 8'd0) begin n_bad++; $display("FAIL rmid_stall: got %0d want 0", stall_count); end
        tick();
        n_cmp++; if (ram[11'h201] !== 8'h00) begin n_bad++; $display("FAIL rmid_ram: got %0h want 0", ram[11'h201]); end
        reset = 0;
        #1;
        n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL first_grant: got %0h want 1", mem_we); end
        tick();
        n_cmp++; if (cpu_ack !== 1'b1) begin n_bad++; $display("FAIL first_ack: got %0h want 1", cpu_ack); end
        cpu_req = 0;
        tick();
        n_cmp++; if (ram[11'h201] !== 8'h77) begin n_bad++; $display("FAIL first_ram: got %0h want 77", ram[11'h201]); end
    endtask

    task automatic test_back_to_back;
        logic prev_ack;
        cpu_req = 1; cpu_we = 0; cpu_addr = 11'h7F0;
        prev_ack = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_cmp++; if (cpu_ack !== 1'((k % 2) == 1)) begin n_bad++; $display("FAIL b2b_ack[%0d]: got %0h want %0h", k, cpu_ack, (k % 2)); end
            n_cmp++; if (prev_ack && cpu_ack) begin n_bad++; $display("FAIL b2b_consecutive[%0d]: got 1,1 want no two acks in a row", k); end
            if (cpu_ack) begin
                n_cmp++; if (cpu_rdata !== 8'hC3) begin n_bad++; $display("FAIL b2b_rdata[%0d]: got %0h want c3", k, cpu_rdata); end
            end
            prev_ack = cpu_ack;
        end
        // now in the ack cycle's successor (issue cycle); go one more to land in an ack cycle
        tick();
        vid_req = 1; vid_addr = 11'h040;
        #1;
        n_cmp++; if (mem_addr !== 11'h040) begin n_bad++; $display("FAIL ovl_issue: got %0h want 040", mem_addr); end
        tick();
        vid_req = 0;
        n_cmp++; if (vid_valid !== 1'b1) begin n_bad++; $display("FAIL ovl_vid_valid: got %0h want 1", vid_valid); end
        n_cmp++; if (vid_data !== 8'h11) begin n_bad++; $display("FAIL ovl_vid_data: got %0h want 11", vid_data); end
        n_cmp++; if (cpu_ack !== 1'b0) begin n_bad++; $display("FAIL ovl_no_ack: got %0h want 0", cpu_ack); end
        n_cmp++; if (stall_count !== 8'd0) begin n_bad++; $display("FAIL ovl_stall: got %0d want 0", stall_count); end
        idle_inputs();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = 8'(i) ^ 8'hA5;
        ram[11'h0AA] = 8'h0F;
        ram[11'h040] = 8'h11;
        ram[11'h7F0] = 8'hC3;
        ram[11'h010] = 8'h3C;
        ram[11'h200] = 8'h00;
        ram[11'h201] = 8'h00;
        mem_rdata = '0;
        reset = 1;
        idle_inputs();

        test_reset();
        test_cpu_write();
        test_collision();
        test_blank_only();
        test_saturate();
        test_reset_mid();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
